// File: rtl/pc_pkg.sv
// pc_pkg: shared types for the program-counter unit.
//   pc_sel_t      - next-PC source selector
//   pc_sel_encode - fixed-priority encoder jal > ret > jump > branch > inc
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_INC,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_RET,
    SEL_JAL
  } pc_sel_t;

  function automatic pc_sel_t pc_sel_encode(input logic jal_en,
                                            input logic ret_en,
                                            input logic jump_en,
                                            input logic branch_en);
    if (jal_en)         return SEL_JAL;
    else if (ret_en)    return SEL_RET;
    else if (jump_en)   return SEL_JUMP;
    else if (branch_en) return SEL_BRANCH;
    else                return SEL_INC;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control/status bundle between the decoder (master) and the
// program-counter unit (slave).
//   master drives : stall, jal_en, ret_en, jump_en, branch_en, src2
//   slave drives  : pc, rlink, ras_count, ras_empty, ras_full,
//                   ras_overflow, ras_underflow
interface pc_unit_if #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             jal_en;
  logic             ret_en;
  logic             jump_en;
  logic             branch_en;
  logic [WIDTH-1:0] src2;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] rlink;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, jal_en, ret_en, jump_en, branch_en, src2,
    input  pc, rlink, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, jal_en, ret_en, jump_en, branch_en, src2,
    output pc, rlink, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/return_stack.sv
// return_stack: circular return-address stack.
//   clk, reset_n   - clock, asynchronous active-low reset
//   push/push_data - write push_data as new top (overwrites oldest when full)
//   pop            - discard top (ignored when empty)
//   top            - current top entry, combinational from state
//   count          - valid entries; full/empty derived from it
//   overflow       - pulse: push while full
//   underflow      - pulse: pop while empty
// The caller guarantees push and pop are never asserted together.
module return_stack import pc_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  // sp_reg is the slot the next push writes; the top lives one below it.
  logic [PTR_W-1:0] sp_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] sp_inc;
  logic [PTR_W-1:0] sp_dec;

  // Explicit wrap so non-power-of-two depths stay circular.
  assign sp_inc = (sp_reg == PTR_W'(DEPTH - 1)) ? '0 : sp_reg + 1'b1;
  assign sp_dec = (sp_reg == '0) ? PTR_W'(DEPTH - 1) : sp_reg - 1'b1;

  assign top       = mem[sp_dec];
  assign count     = count_reg;
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign overflow  = push & full;
  assign underflow = pop & empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_reg    <= '0;
      count_reg <= '0;
    end else if (push) begin
      // When full, sp_reg already points at the oldest entry, so the write
      // below overwrites it and the count saturates.
      sp_reg <= sp_inc;
      if (!full) count_reg <= count_reg + 1'b1;
    end else if (pop && !empty) begin
      sp_reg    <= sp_dec;
      count_reg <= count_reg - 1'b1;
    end
  end

  // Entry contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[sp_reg] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: registered program counter with return-address stack.
//   clk, reset_n - clock, asynchronous active-low reset
//   bus (slave)  - stall and jal/ret/jump/branch enables with src2 in;
//                  pc, rlink, ras_count/empty/full and sticky
//                  ras_overflow/ras_underflow out (all registered state)
// Next PC priority: jal > ret > jump > branch > increment. stall holds all
// state. A return on an empty stack falls back to src2.
module pc_unit import pc_pkg::*; #(
  parameter int              WIDTH     = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic    clk,
  input  logic    reset_n,
  pc_unit_if.slave bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  pc_sel_t          sel;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] rlink_reg, rlink_next;
  logic [WIDTH-1:0] pc_plus1;
  logic             ovf_reg, unf_reg;
  logic             push, pop;
  logic [WIDTH-1:0] ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_full, ras_empty, ras_ovf_pulse, ras_unf_pulse;

  assign sel      = pc_sel_encode(bus.jal_en, bus.ret_en, bus.jump_en, bus.branch_en);
  assign pc_plus1 = pc_reg + 1'b1;

  // Stack side effects only for the winning selection, never during stall.
  assign push = !bus.stall && (sel == SEL_JAL);
  assign pop  = !bus.stall && (sel == SEL_RET);

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (ras_ovf_pulse),
    .underflow (ras_unf_pulse)
  );

  always_comb begin
    pc_next    = pc_plus1;
    rlink_next = rlink_reg;
    unique case (sel)
      SEL_JAL: begin
        pc_next    = bus.src2;
        rlink_next = pc_plus1;
      end
      SEL_RET:    pc_next = ras_empty ? bus.src2 : ras_top;
      SEL_JUMP:   pc_next = bus.src2;
      // src2 is already WIDTH bits, so modulo-2^WIDTH addition is the
      // same as adding the sign-extended offset.
      SEL_BRANCH: pc_next = pc_reg + bus.src2;
      default:    pc_next = pc_plus1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg    <= RESET_PC;
      rlink_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else if (!bus.stall) begin
      pc_reg    <= pc_next;
      rlink_reg <= rlink_next;
      if (ras_ovf_pulse) ovf_reg <= 1'b1;
      if (ras_unf_pulse) unf_reg <= 1'b1;
    end
  end

  assign bus.pc            = pc_reg;
  assign bus.rlink         = rlink_reg;
  assign bus.ras_count     = ras_count;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_overflow  = ovf_reg;
  assign bus.ras_underflow = unf_reg;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(16), .RAS_DEPTH(4)) bus ();

  pc_unit #(
    .WIDTH     (16),
    .RAS_DEPTH (4),
    .RESET_PC  (16'h0100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the stack is a queue, newest at the back.
  logic [15:0] m_pc, m_rlink;
  logic [15:0] m_stack[$];
  logic        m_ovf, m_unf;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".pc"},    bus.pc, m_pc);
    cmp({tag, ".rlink"}, bus.rlink, m_rlink);
    cmp({tag, ".count"}, 16'(bus.ras_count), 16'(m_stack.size()));
    cmp({tag, ".empty"}, 16'(bus.ras_empty), 16'(m_stack.size() == 0));
    cmp({tag, ".full"},  16'(bus.ras_full), 16'(m_stack.size() == 4));
    cmp({tag, ".ovf"},   16'(bus.ras_overflow), 16'(m_ovf));
    cmp({tag, ".unf"},   16'(bus.ras_underflow), 16'(m_unf));
  endtask

  task automatic model_reset();
    m_pc    = 16'h0100;
    m_rlink = 16'h0000;
    m_stack.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic jal, input logic ret,
                            input logic jmp, input logic br, input logic [15:0] s2);
    if (st) return;
    if (jal) begin
      if (m_stack.size() == 4) begin
        void'(m_stack.pop_front());
        m_ovf = 1'b1;
      end
      m_stack.push_back(m_pc + 16'd1);
      m_rlink = m_pc + 16'd1;
      m_pc    = s2;
    end else if (ret) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_pc  = s2;
        m_unf = 1'b1;
      end
    end else if (jmp) m_pc = s2;
    else if (br) m_pc = m_pc + s2;
    else m_pc = m_pc + 16'd1;
  endtask

  // Called 1 time unit after a rising edge: drive, advance one edge, check.
  task automatic step(input string tag, input logic st, input logic jal, input logic ret,
                      input logic jmp, input logic br, input logic [15:0] s2);
    bus.stall = st; bus.jal_en = jal; bus.ret_en = ret;
    bus.jump_en = jmp; bus.branch_en = br; bus.src2 = s2;
    model_step(st, jal, ret, jmp, br, s2);
    @(posedge clk);
    #1;
    check_all(tag);
    $display("step %-10s st=%b jal=%b ret=%b jmp=%b br=%b src2=%h -> pc=%h rlink=%h cnt=%0d ovf=%b unf=%b",
             tag, st, jal, ret, jmp, br, s2, bus.pc, bus.rlink, bus.ras_count,
             bus.ras_overflow, bus.ras_underflow);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.stall = 1'b0; bus.jal_en = 1'b0; bus.ret_en = 1'b0;
    bus.jump_en = 1'b0; bus.branch_en = 1'b0; bus.src2 = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // Increment after reset
    idle("inc1"); cmp("inc1_c", bus.pc, 16'h0101);
    idle("inc2"); cmp("inc2_c", bus.pc, 16'h0102);
    idle("inc3"); cmp("inc3_c", bus.pc, 16'h0103);

    // Branches and wrap
    step("jmp10", 0, 0, 0, 1, 0, 16'h0010);
    step("brneg", 0, 0, 0, 0, 1, 16'hFFFC); cmp("brneg_c", bus.pc, 16'h000C);
    step("brpos", 0, 0, 0, 0, 1, 16'h0005); cmp("brpos_c", bus.pc, 16'h0011);
    step("jmpff", 0, 0, 0, 1, 0, 16'hFFFF);
    idle("wrap");                           cmp("wrap_c", bus.pc, 16'h0000);

    // JAL then RET
    step("jmp20", 0, 0, 0, 1, 0, 16'h0020);
    step("jal",   0, 1, 0, 0, 0, 16'h0200);
    cmp("jal_pc", bus.pc, 16'h0200);
    cmp("jal_rl", bus.rlink, 16'h0021);
    cmp("jal_cnt", 16'(bus.ras_count), 16'd1);
    idle("mid");
    step("ret",   0, 0, 1, 0, 0, 16'h0000);
    cmp("ret_pc", bus.pc, 16'h0021);
    cmp("ret_emp", 16'(bus.ras_empty), 16'd1);

    // Overflow and underflow
    step("jmp10b", 0, 0, 0, 1, 0, 16'h0010);
    for (int i = 0; i < 5; i++)
      step($sformatf("jalx%0d", i), 0, 1, 0, 0, 0, 16'(16'h0020 + 16'(i) * 16'h0010));
    cmp("ovf_full", 16'(bus.ras_full), 16'd1);
    cmp("ovf_flag", 16'(bus.ras_overflow), 16'd1);
    step("pop1", 0, 0, 1, 0, 0, 16'h0000); cmp("pop1_c", bus.pc, 16'h0051);
    step("pop2", 0, 0, 1, 0, 0, 16'h0000); cmp("pop2_c", bus.pc, 16'h0041);
    step("pop3", 0, 0, 1, 0, 0, 16'h0000); cmp("pop3_c", bus.pc, 16'h0031);
    step("pop4", 0, 0, 1, 0, 0, 16'h0000); cmp("pop4_c", bus.pc, 16'h0021);
    step("pop5", 0, 0, 1, 0, 0, 16'h0777); cmp("pop5_c", bus.pc, 16'h0777);
    cmp("unf_flag", 16'(bus.ras_underflow), 16'd1);

    // Priority and stall
    step("prio",  0, 1, 1, 0, 1, 16'h0300);
    cmp("prio_pc", bus.pc, 16'h0300);
    cmp("prio_cnt", 16'(bus.ras_count), 16'd1);
    step("stall", 1, 1, 0, 0, 0, 16'h0400);
    cmp("stall_pc", bus.pc, 16'h0300);
    cmp("stall_cnt", 16'(bus.ras_count), 16'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic st, jal, ret, jmp, br;
      st  = ($urandom_range(0, 7) == 0);
      jal = ($urandom_range(0, 3) == 0);
      ret = ($urandom_range(0, 3) == 0);
      jmp = ($urandom_range(0, 4) == 0);
      br  = ($urandom_range(0, 2) == 0);
      step($sformatf("rnd%0d", i), st, jal, ret, jmp, br, 16'($urandom));
    end

    // Asynchronous reset mid-cycle with three entries on the stack
    for (int i = 0; i < 5; i++) step($sformatf("drain%0d", i), 0, 0, 1, 0, 0, 16'h0500);
    for (int i = 0; i < 3; i++) step($sformatf("fill%0d", i), 0, 1, 0, 0, 0, 16'(16'h0600 + 16'(i)));
    cmp("pre_rst_cnt", 16'(bus.ras_count), 16'd3);
    bus.jal_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    cmp("arst_pc", bus.pc, 16'h0100);
    cmp("arst_cnt", 16'(bus.ras_count), 16'd0);
    cmp("arst_ovf", 16'(bus.ras_overflow), 16'd0);
    cmp("arst_unf", 16'(bus.ras_underflow), 16'd0);
    check_all("arst");
    #1;
    reset_n = 1'b1;
    idle("post1"); cmp("post1_c", bus.pc, 16'h0101);
    idle("post2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
